// File: rtl/slc3_mmio_pkg.sv
// Shared constants, state encoding and address decode for the SLC-3 memory/MMIO responder.
package slc3_mmio_pkg;

  localparam int          DATA_W      = 16;
  localparam logic [15:0] ADDR_HEX_SW = 16'hFFFF;
  localparam logic [15:0] ADDR_LED    = 16'hFFFE;
  localparam int          RAM_RD_LAT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WAIT,
    DONE,
    HOLD
  } state_t;

  function automatic logic is_mmio(input logic [15:0] a);
    return (a == ADDR_HEX_SW) || (a == ADDR_LED);
  endfunction

endpackage

// File: rtl/slc3_sync2.sv
// Two-flop synchronizer for a bus of quasi-static inputs (switches), async reset to zero.
module slc3_sync2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/slc3_mmio_resp.sv
// SLC-3 memory responder: turns a 3-cycle CPU access window into one RAM/MMIO access and a rdy pulse.
// Define SLC3_SW_SYNC_EN to pass the switch inputs through a two-flop synchronizer before the read mux.
module slc3_mmio_resp
  import slc3_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rdy,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output logic [15:0] led_o
);

  state_t      state;
  logic [15:0] cap_addr;
  logic [15:0] cap_data;
  logic        cap_wr;
  logic [1:0]  wait_cnt;
  logic [15:0] sw_val;

`ifdef SLC3_SW_SYNC_EN
  slc3_sync2 #(.DATA_W(DATA_W)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_i),
    .q     (sw_val)
  );
`else
  assign sw_val = sw_i;
`endif

  function automatic logic [15:0] rd_mux(input logic [15:0] a, input logic [15:0] ram,
                                         input logic [15:0] sw, input logic [15:0] led);
    if (a == ADDR_HEX_SW)   return sw;
    else if (a == ADDR_LED) return led;
    else                    return ram;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_wr    <= 1'b0;
      wait_cnt  <= '0;
      rdata     <= '0;
      rdy       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      hex_o     <= '0;
      led_o     <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      rdy    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_ena) begin
            cap_addr <= addr;
            cap_data <= wdata;
            cap_wr   <= mem_wr_ena;
            // RAM strobes are registered here so they are high exactly during ACCEPT.
            if (!is_mmio(addr)) begin
              ram_en    <= 1'b1;
              ram_we    <= mem_wr_ena;
              ram_addr  <= addr;
              ram_wdata <= wdata;
            end
            state <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (cap_wr && cap_addr == ADDR_HEX_SW) hex_o <= cap_data;
          if (cap_wr && cap_addr == ADDR_LED)    led_o <= cap_data;
          wait_cnt <= 2'(RAM_RD_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            if (!cap_wr) rdata <= rd_mux(cap_addr, ram_rdata, sw_val, led_o);
            rdy   <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          // A still-high mem_ena belongs to the finished access and must not start another.
          state <= mem_ena ? HOLD : IDLE;
        end
        HOLD: begin
          if (!mem_ena) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mmio_resp.sv
// Scoreboard bench for slc3_mmio_resp: RAM model, expected rdata queue, per-access strobe/timing checks.
module tb_slc3_mmio_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ena;
  logic        mem_wr_ena;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdy;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] sw_i;
  logic [15:0] hex_o;
  logic [15:0] led_o;

  always #5 clk = ~clk;

  slc3_mmio_resp dut (
    .clk        (clk),
    .reset      (reset),
    .mem_ena    (mem_ena),
    .mem_wr_ena (mem_wr_ena),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdy        (rdy),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .sw_i       (sw_i),
    .hex_o      (hex_o),
    .led_o      (led_o)
  );

  // Synchronous RAM model, one-cycle read latency.
  logic [15:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr[7:0]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [15:0] sb_q[$];
  int          en_cnt  = 0;
  int          we_cnt  = 0;
  int          rdy_cnt = 0;

  always @(negedge clk) begin
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_we) we_cnt <= we_cnt + 1;
    if (rdy) begin
      rdy_cnt <= rdy_cnt + 1;
      if (sb_q.size() == 0) check_eq("rdy_unexpected", {31'd0, rdy}, 32'd0);
      else                  check_eq("rdata_at_rdy", {16'd0, rdata}, {16'd0, sb_q.pop_front()});
    end
  end

  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_hex, exp_led, exp_rdata, last_addr, last_wdata;

  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int hold, input logic chg, input logic [15:0] sw_new);
    int   en0, we0, rdy0, got_k;
    logic mmio;
    mmio  = (a == 16'hFFFF) || (a == 16'hFFFE);
    en0   = en_cnt;
    we0   = we_cnt;
    rdy0  = rdy_cnt;
    got_k = -1;
    if (wr) begin
      if (a == 16'hFFFF)      exp_hex = d;
      else if (a == 16'hFFFE) exp_led = d;
      else                    ref_mem[a[7:0]] = d;
    end else begin
      if (a == 16'hFFFE) exp_rdata = exp_led;
      else if (a == 16'hFFFF) begin
`ifdef SLC3_SW_SYNC_EN
        exp_rdata = sw_i;
`else
        exp_rdata = chg ? sw_new : sw_i;
`endif
      end else exp_rdata = ref_mem[a[7:0]];
    end
    if (!mmio) begin
      last_addr  = a;
      last_wdata = d;
    end
    sb_q.push_back(exp_rdata);
    @(negedge clk);
    mem_ena    = 1'b1;
    mem_wr_ena = wr;
    addr       = a;
    wdata      = d;
    for (int k = 1; k <= hold + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr       = ~a;
        wdata      = ~d;
        mem_wr_ena = ~wr;
        if (chg) sw_i = sw_new;
      end
      if (k == hold) mem_ena = 1'b0;
      if (rdy && got_k < 0) got_k = k;
    end
    check_eq("rdy_cycle", got_k, 32'd3);
    check_eq("rdy_pulses", rdy_cnt - rdy0, 32'd1);
    check_eq("ram_en_pulses", en_cnt - en0, mmio ? 32'd0 : 32'd1);
    check_eq("ram_we_pulses", we_cnt - we0, (wr && !mmio) ? 32'd1 : 32'd0);
    check_eq("ram_addr", {16'd0, ram_addr}, {16'd0, last_addr});
    check_eq("ram_wdata", {16'd0, ram_wdata}, {16'd0, last_wdata});
    check_eq("hex_o", {16'd0, hex_o}, {16'd0, exp_hex});
    check_eq("led_o", {16'd0, led_o}, {16'd0, exp_led});
    check_eq("rdata_after", {16'd0, rdata}, {16'd0, exp_rdata});
  endtask

  task automatic reset_mid_read(input logic [15:0] a);
    int rdy0;
    rdy0 = rdy_cnt;
    @(negedge clk);
    mem_ena    = 1'b1;
    mem_wr_ena = 1'b0;
    addr       = a;
    @(negedge clk);
    @(negedge clk);
    mem_ena = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_hex = '0; exp_led = '0; exp_rdata = '0; last_addr = '0; last_wdata = '0;
    check_eq("rst_no_rdy", rdy_cnt - rdy0, 32'd0);
    check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
    check_eq("rst_state_idle", {29'd0, dut.state}, 32'd0);
    check_eq("rst_hex_led", {hex_o, led_o}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mem_ena = 1'b0; mem_wr_ena = 1'b0;
    addr = '0; wdata = '0; sw_i = '0;
    exp_hex = '0; exp_led = '0; exp_rdata = '0; last_addr = '0; last_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("reset_rdata_rdy", {15'd0, rdy, rdata}, 32'd0);
    check_eq("reset_ram_ctl", {30'd0, ram_en, ram_we}, 32'd0);
    check_eq("reset_ram_bus", {ram_addr, ram_wdata}, 32'd0);
    check_eq("reset_hex_led", {hex_o, led_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    access(1'b1, 16'h0040, 16'h1234, 3, 1'b0, 16'h0);
    access(1'b0, 16'h0040, 16'h0000, 3, 1'b0, 16'h0);
    access(1'b1, 16'hFFFF, 16'h00AB, 3, 1'b0, 16'h0);
    access(1'b1, 16'hFFFE, 16'h5A5A, 3, 1'b0, 16'h0);
    access(1'b0, 16'hFFFE, 16'h0000, 3, 1'b0, 16'h0);
    sw_i = 16'hBEEF;
    repeat (3) @(negedge clk);
    access(1'b0, 16'hFFFF, 16'h0000, 3, 1'b0, 16'h0);
    access(1'b0, 16'hFFFF, 16'h0000, 3, 1'b1, 16'hCAFE);
    access(1'b1, 16'h0041, 16'h7777, 8, 1'b0, 16'h0);
    access(1'b0, 16'h0041, 16'h0000, 8, 1'b0, 16'h0);
    access(1'b1, 16'h0042, 16'h3C3C, 1, 1'b0, 16'h0);
    access(1'b0, 16'h0042, 16'h0000, 1, 1'b0, 16'h0);
    reset_mid_read(16'h0041);
    access(1'b0, 16'h0040, 16'h0000, 3, 1'b0, 16'h0);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slc3_mmio_resp.md
SLC3_MMIO_RESP -- requirements
Module: slc3_mmio_resp

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port mem_ena, input, 1, CPU memory-operation enable; asserted for a 3-cycle access window.
REQ-004 SHALL have port mem_wr_ena, input, 1, write qualifier, valid when mem_ena is high.
REQ-005 SHALL have port addr, input, 16, CPU address (MAR).
REQ-006 SHALL have port wdata, input, 16, CPU write data (MDR).
REQ-007 SHALL have port rdata, output, 16, read data returned to MDR.
REQ-008 SHALL have port rdy, output, 1, one-cycle pulse when the access completes.
REQ-009 SHALL have ports ram_en (output, 1), ram_we (output, 1), ram_addr (output, 16), ram_wdata (output, 16) and ram_rdata (input, 16), the synchronous RAM port with 1-cycle read latency.
REQ-010 SHALL have port sw_i, input, 16, switch inputs.
REQ-011 SHALL have port hex_o, output, 16, hex display register.
REQ-012 SHALL have port led_o, output, 16, LED register.

Function
REQ-013 SHALL implement states IDLE, ACCEPT, WAIT, DONE and HOLD.
REQ-014 IDLE: when mem_ena=1, SHALL capture addr, wdata and mem_wr_ena into internal registers and go to ACCEPT; otherwise stay in IDLE.
REQ-015 ACCEPT: when the captured address is neither 0xFFFE nor 0xFFFF, SHALL drive ram_en=1, ram_addr=captured addr, ram_we=captured wr, and ram_wdata=captured data for exactly this cycle; SHALL then go to WAIT.
REQ-016 ACCEPT, captured address 0xFFFF with write: SHALL load hex_o from the captured data; with read: no side effect.
REQ-017 ACCEPT, captured address 0xFFFE with write: SHALL load led_o from the captured data.
REQ-018 WAIT: for a read, SHALL load rdata from ram_rdata (RAM), from sw_i or the synchronised sw (0xFFFF), or from led_o (0xFFFE); SHALL then go to DONE.
REQ-019 WAIT, for a write: rdata SHALL be unchanged.
REQ-020 DONE: SHALL assert rdy=1 for one cycle, 3 cycles after request capture; rdata SHALL be stable from DONE until the next read's WAIT.
REQ-021 DONE: SHALL go to HOLD when mem_ena=1, else to IDLE.
REQ-022 HOLD: SHALL wait for mem_ena=0 and then go to IDLE; a held-high mem_ena SHALL never re-issue an access.
REQ-023 mem_ena falling during ACCEPT or WAIT SHALL NOT abort the access: the RAM/MMIO write completes, rdata updates and rdy still pulses (access atomic once captured).
REQ-024 Outside ACCEPT, ram_en=0 and ram_we=0; ram_addr and ram_wdata SHALL hold their last values.
REQ-025 addr/wdata changes after capture SHALL be ignored until the next IDLE capture.

Reset
REQ-026 On reset=1, SHALL asynchronously force state=IDLE; rdata, hex_o, led_o, ram_addr and ram_wdata to 0x0000; rdy, ram_en and ram_we to 0; all capture registers to 0.
REQ-027 Reset mid-access SHALL discard the access: no rdy pulse, and no RAM write if asserted before ACCEPT.

Configuration
REQ-028 With macro SLC3_SW_SYNC_EN defined, sw_i SHALL pass through a two-flop synchronizer (reset 0x0000) before the read mux, so a switch change is visible to reads 2 cycles later.
REQ-029 With SLC3_SW_SYNC_EN undefined, sw_i SHALL be sampled directly in WAIT.

Structure
REQ-030 Package slc3_mmio_pkg SHALL hold ADDR_HEX_SW=16'hFFFF, ADDR_LED=16'hFFFE, the state enum typedef and RAM_RD_LAT=1.
REQ-031 The synchronizer SHALL be sub-module slc3_sync2 (16-bit, async reset), instantiated only under SLC3_SW_SYNC_EN.

Verification
REQ-032 Write 0x1234 to addr 0x0040 (mem_ena high 3 cycles, wr=1) -> ram_we=1, ram_addr=0x0040, ram_wdata=0x1234 in exactly one cycle; rdy pulses in cycle 4.
REQ-033 Read 0x0040 with RAM model returning 0x1234 -> rdata=0x1234 when rdy=1; ram_we=0 throughout.
REQ-034 Write 0x00AB to 0xFFFF, then 0x5A5A to 0xFFFE -> hex_o=0x00AB, led_o=0x5A5A; no ram_en asserted; read 0xFFFE -> rdata=0x5A5A.
REQ-035 sw_i=0xBEEF, read 0xFFFF -> rdata=0xBEEF; with SLC3_SW_SYNC_EN, a change to sw_i within 2 cycles of the read returns the old value.
REQ-036 mem_ena held high 8 cycles -> exactly one ram_en pulse and one rdy pulse; a new access starts only after mem_ena drops.
REQ-037 Reset asserted during WAIT of a read -> no rdy pulse, rdata=0x0000, state IDLE; the next access completes normally.
